// File: rtl/tm1638_frame_sequencer.sv
// tm1638_frame_sequencer: runs one TM1638 refresh frame per request:
//   mode cmd 0x40, address cmd 0xC0 + 16 display bytes, display-control cmd 0x88|brightness,
//   and, with key scan enabled, read cmd 0x42, DIO turn-around and a 4-byte key read.
// Latency: busy rises the cycle after an accepted frame_req; frame_done/key_valid pulse in the
//   final cycle. Requests made while busy merge into one pending frame, which starts right after.
// Ports: clk, rst (async, active low), frame_req/seg/led/brightness from lab logic,
//   busy/frame_done/keys/key_valid status, sio_stb/sio_clk/sio_dout/sio_doe/sio_din to the pad.
// Build option: define TM1638_KEY_SCAN_EN to include the key read phase (default: display only).
module tm1638_frame_sequencer #(
  parameter int CLK_MHZ = 50,
  parameter int SIO_KHZ = 1000,
  parameter int TURN_US = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_req,
  input  logic [63:0] seg,
  input  logic [7:0]  led,
  input  logic [2:0]  brightness,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  keys,
  output logic        key_valid,
  output logic        sio_stb,
  output logic        sio_clk,
  output logic        sio_dout,
  output logic        sio_doe,
  input  logic        sio_din
);

  localparam int CW = 16;
  localparam int HALF = CLK_MHZ * 1000 / (2 * SIO_KHZ);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_MODE, S_ADDR, S_DISP, S_RCMD, S_TURN, S_READ, S_GAP, S_DONE
  } state_t;

  state_t        state, gap_next, load_state;
  logic [CW-1:0] cnt;
  logic          phase;      // 0: sio_clk low half, 1: high half (GAP: first/second half)
  logic [2:0]    bit_cnt;
  logic [4:0]    byte_cnt, load_idx;
  logic [7:0]    sh, nb;
  logic [63:0]   seg_sh;
  logic [7:0]    led_sh;
  logic [2:0]    bri_sh;
  logic          pending;

`ifdef TM1638_KEY_SCAN_EN
  localparam logic [CW-1:0] TURN_M1 = CW'(CLK_MHZ * TURN_US - 1);
  logic [7:0] key_buf;
`else
  logic unused_din;
  assign unused_din = sio_din;
`endif

  // Byte idx of a command state; ADDR idx 0 is the 0xC0 cmd, idx 1..16 are addresses 0..15.
  function automatic logic [7:0] byte_for(input state_t s, input logic [4:0] idx);
    logic [3:0] a;
    a = idx[3:0] - 4'd1;
    case (s)
      S_MODE: byte_for = 8'h40;
      S_ADDR: begin
        if (idx == 5'd0)  byte_for = 8'hC0;
        else if (a[0])    byte_for = {7'b0, led_sh[a[3:1]]};
        else              byte_for = seg_sh[{a[3:1], 3'b000} +: 8];
      end
      S_DISP: byte_for = {5'b10001, bri_sh};
      S_RCMD: byte_for = 8'h42;
      default: byte_for = 8'hFF;
    endcase
  endfunction

  function automatic logic [4:0] last_idx(input state_t s);
    case (s)
      S_ADDR:  last_idx = 5'd16;
      S_READ:  last_idx = 5'd3;
      default: last_idx = 5'd0;
    endcase
  endfunction

  // Next byte to load: first byte of the state after a GAP, MODE when a frame starts,
  // otherwise the following byte of the current state.
  always_comb begin
    load_state = state;
    load_idx   = byte_cnt + 5'd1;
    if (state == S_GAP) begin
      load_state = gap_next;
      load_idx   = '0;
    end else if (state == S_IDLE || state == S_DONE) begin
      load_state = S_MODE;
      load_idx   = '0;
    end
    nb = byte_for(load_state, load_idx);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      gap_next   <= S_IDLE;
      cnt        <= '0;
      phase      <= 1'b0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      sh         <= 8'hFF;
      seg_sh     <= '0;
      led_sh     <= '0;
      bri_sh     <= '0;
      pending    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      keys       <= '0;
      key_valid  <= 1'b0;
      sio_stb    <= 1'b1;
      sio_clk    <= 1'b1;
      sio_dout   <= 1'b1;
      sio_doe    <= 1'b0;
`ifdef TM1638_KEY_SCAN_EN
      key_buf    <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      key_valid  <= 1'b0;
      if (frame_req && state != S_IDLE) pending <= 1'b1;

      case (state)
        S_IDLE, S_DONE: begin
          if (frame_req || (state == S_DONE && pending)) begin
            seg_sh   <= seg;
            led_sh   <= led;
            bri_sh   <= brightness;
            pending  <= 1'b0;
            busy     <= 1'b1;
            sio_doe  <= 1'b1;
            state    <= S_MODE;
            sio_stb  <= 1'b0;
            sio_clk  <= 1'b0;
            sh       <= nb;
            sio_dout <= nb[0];
            cnt      <= '0;
            phase    <= 1'b0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
          end else if (state == S_DONE) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            sio_doe <= 1'b0;
          end
        end

        S_MODE, S_ADDR, S_DISP, S_RCMD, S_READ: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!phase) begin
              phase   <= 1'b1;
              sio_clk <= 1'b1;
`ifdef TM1638_KEY_SCAN_EN
              if (state == S_READ && bit_cnt == 3'd0) key_buf[{1'b0, byte_cnt[1:0]}] <= sio_din;
              if (state == S_READ && bit_cnt == 3'd4) key_buf[{1'b1, byte_cnt[1:0]}] <= sio_din;
`endif
            end else begin
              phase <= 1'b0;
              if (bit_cnt != 3'd7) begin
                bit_cnt  <= bit_cnt + 3'd1;
                sio_clk  <= 1'b0;
                sio_dout <= sh[1];
                sh       <= {1'b1, sh[7:1]};
              end else begin
                bit_cnt <= '0;
                if (byte_cnt != last_idx(state)) begin
                  byte_cnt <= byte_cnt + 5'd1;
                  sio_clk  <= 1'b0;
                  sh       <= nb;
                  sio_dout <= nb[0];
                end else begin
                  byte_cnt <= '0;
                  case (state)
                    S_MODE: begin state <= S_GAP; gap_next <= S_ADDR; sio_stb <= 1'b1; sio_dout <= 1'b1; end
                    S_ADDR: begin state <= S_GAP; gap_next <= S_DISP; sio_stb <= 1'b1; sio_dout <= 1'b1; end
`ifdef TM1638_KEY_SCAN_EN
                    S_DISP: begin state <= S_GAP; gap_next <= S_RCMD; sio_stb <= 1'b1; sio_dout <= 1'b1; end
                    // STB stays low across the turn-around and the read bytes.
                    S_RCMD: begin state <= S_TURN; sio_doe <= 1'b0; sio_dout <= 1'b1; end
                    S_READ: begin
                      state    <= S_GAP;
                      gap_next <= S_DONE;
                      sio_stb  <= 1'b1;
                      sio_doe  <= 1'b1;
                    end
`else
                    S_DISP: begin state <= S_GAP; gap_next <= S_DONE; sio_stb <= 1'b1; sio_dout <= 1'b1; end
`endif
                    default: state <= S_IDLE;
                  endcase
                end
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef TM1638_KEY_SCAN_EN
        S_TURN: begin
          if (cnt == TURN_M1) begin
            cnt      <= '0;
            state    <= S_READ;
            sio_clk  <= 1'b0;
            sh       <= 8'hFF;
            phase    <= 1'b0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        S_GAP: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!phase) begin
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (gap_next == S_DONE) begin
                state      <= S_DONE;
                frame_done <= 1'b1;
`ifdef TM1638_KEY_SCAN_EN
                keys       <= key_buf;
                key_valid  <= 1'b1;
`endif
              end else begin
                state    <= gap_next;
                sio_stb  <= 1'b0;
                sio_clk  <= 1'b0;
                sh       <= nb;
                sio_dout <= nb[0];
                bit_cnt  <= '0;
                byte_cnt <= '0;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_frame_sequencer.sv
// tb_tm1638_frame_sequencer: drives random frames into tm1638_frame_sequencer and checks the
//   serial bus against a TM1638 byte-level model, plus keys, busy/frame_done timing, merged
//   requests and mid-frame reset. Works with or without TM1638_KEY_SCAN_EN defined.
module tb_tm1638_frame_sequencer;

  localparam int HALF = 25;
  localparam int TURN = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_req = 1'b0;
  logic [63:0] seg = '0;
  logic [7:0]  led = '0;
  logic [2:0]  brightness = '0;
  logic        busy, frame_done, key_valid;
  logic [7:0]  keys;
  logic        sio_stb, sio_clk, sio_dout, sio_doe;
  logic        din = 1'b1;

  int checks = 0;
  int errors = 0;

  tm1638_frame_sequencer #(.CLK_MHZ(50), .SIO_KHZ(1000), .TURN_US(2)) dut (
    .clk(clk), .rst(rst), .frame_req(frame_req), .seg(seg), .led(led),
    .brightness(brightness), .busy(busy), .frame_done(frame_done), .keys(keys),
    .key_valid(key_valid), .sio_stb(sio_stb), .sio_clk(sio_clk), .sio_dout(sio_dout),
    .sio_doe(sio_doe), .sio_din(din)
  );

  always #10 clk = ~clk;

  // ---------------- TM1638 bus model ----------------
  // Received bytes go into rx_q; -1 marks STB returning high (end of a command).
  int         rx_q[$];
  int         exp_q[$];
  logic [7:0] rd_bytes [4];
  logic [7:0] rx_sh = '0;
  int         rx_bits = 0;
  int         rb = 0;
  int         doe_drop = 0;
  logic       prev_sclk = 1'b1;
  logic       prev_stb = 1'b1;

  always @(negedge clk) begin
    if (sio_clk && !prev_sclk && !sio_stb && sio_doe) begin
      rx_sh = {sio_dout, rx_sh[7:1]};
      rx_bits++;
      if (rx_bits == 8) begin
        rx_q.push_back(int'(rx_sh));
        rx_bits = 0;
      end
    end
    if (!sio_clk && prev_sclk && !sio_stb && !sio_doe) begin
      if (rb < 32) din = rd_bytes[rb / 8][rb % 8];
      rb++;
    end
    if (sio_stb && !prev_stb) begin
      rx_q.push_back(-1);
      rx_bits = 0;
      rb = 0;
      din = 1'b1;
    end
    if (busy && !sio_doe) doe_drop++;
    prev_sclk = sio_clk;
    prev_stb  = sio_stb;
  end

  // ---------------- reference model ----------------
  task automatic add_exp(input logic [63:0] s, input logic [7:0] l, input logic [2:0] b);
    exp_q.push_back(8'h40);
    exp_q.push_back(-1);
    exp_q.push_back(8'hC0);
    for (int a = 0; a < 16; a++) begin
      if (a % 2 == 0) exp_q.push_back(int'(s[8 * (a / 2) +: 8]));
      else            exp_q.push_back(int'(l[a / 2]));
    end
    exp_q.push_back(-1);
    exp_q.push_back(8'h88 + int'(b));
    exp_q.push_back(-1);
`ifdef TM1638_KEY_SCAN_EN
    exp_q.push_back(8'h42);
    exp_q.push_back(-1);
`endif
  endtask

  function automatic logic [7:0] model_keys();
    logic [7:0] k;
    k = '0;
`ifdef TM1638_KEY_SCAN_EN
    for (int b = 0; b < 4; b++) begin
      k[b]     = rd_bytes[b][0];
      k[b + 4] = rd_bytes[b][4];
    end
`endif
    return k;
  endfunction

  function automatic int frame_cycles();
    int bits, gaps, turn;
    bits = 8 + 17 * 8 + 8;
    gaps = 3;
    turn = 0;
`ifdef TM1638_KEY_SCAN_EN
    bits += 8 + 32;
    gaps += 1;
    turn = TURN;
`endif
    return bits * 2 * HALF + gaps * 2 * HALF + turn + 1;
  endfunction

  function automatic int stream_diff();
    int n;
    n = 0;
    if (rx_q.size() != exp_q.size()) return 1000 + rx_q.size();
    foreach (exp_q[i]) if (rx_q[i] != exp_q[i]) n++;
    return n;
  endfunction

  function automatic logic exp_kv();
`ifdef TM1638_KEY_SCAN_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Waits for frame_done; counts busy cycles; captures key outputs in the done cycle.
  int         w_cyc;
  bit         w_seen;
  logic       w_kv;
  logic [7:0] w_keys;
  task automatic wait_done();
    w_cyc = 0; w_seen = 0; w_kv = 1'b0; w_keys = '0;
    for (int i = 0; i < 12000 && !w_seen; i++) begin
      @(negedge clk);
      if (busy) w_cyc++;
      if (frame_done) begin
        w_seen = 1; w_kv = key_valid; w_keys = keys;
      end
    end
  endtask

  task automatic randomize_inputs();
    seg = {$urandom, $urandom};
    led = 8'($urandom);
    brightness = 3'($urandom);
  endtask

  task automatic randomize_reads();
    for (int b = 0; b < 4; b++) rd_bytes[b] = 8'($urandom);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ({sio_stb, sio_clk, sio_dout, sio_doe, busy, frame_done, key_valid} !== 7'b1110000 || keys !== 8'h00) begin
      errors++;
      $display("FAIL reset_values stb/clk/dout/doe/busy/done/kv=%b keys=%h required 1110000 keys=00",
               {sio_stb, sio_clk, sio_dout, sio_doe, busy, frame_done, key_valid}, keys);
    end
    rst = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sio_stb !== 1'b1 || sio_doe !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b stb=%b doe=%b required 0 1 0", busy, sio_stb, sio_doe);
    end
    rx_q = {};
  endtask

  task automatic test_basic_frame();
    int d;
    exp_q = {}; rx_q = {};
    seg = {$urandom, $urandom};
    seg[7:0] = 8'h3F;
    led = 8'h01;
    brightness = 3'd7;
    rd_bytes[0] = 8'h01; rd_bytes[1] = 8'h00; rd_bytes[2] = 8'h10; rd_bytes[3] = 8'h00;
    add_exp(seg, led, brightness);
    @(negedge clk);
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_rise busy=%b required 1", busy);
    end
    randomize_inputs();  // shadow copy must make this invisible
    wait_done();
    w_cyc++;  // the first busy cycle was sampled above
    checks++;
    if (!w_seen) begin
      errors++;
      $display("FAIL basic_done_timeout frame_done never seen");
    end
    checks++;
    if (w_cyc != frame_cycles()) begin
      errors++;
      $display("FAIL basic_busy_cycles got %0d required %0d", w_cyc, frame_cycles());
    end
    d = stream_diff();
    checks++;
    if (d != 0) begin
      errors++;
      $display("FAIL basic_stream diff=%0d got %0d bytes required %0d", d, rx_q.size(), exp_q.size());
    end
    checks++;
    if (w_keys !== model_keys() || w_kv !== exp_kv()) begin
      errors++;
      $display("FAIL basic_keys keys=%h kv=%b required keys=%h kv=%b", w_keys, w_kv, model_keys(), exp_kv());
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_end busy=%b done=%b kv=%b required 0 0 0", busy, frame_done, key_valid);
    end
  endtask

  task automatic test_random_frame();
    int d;
    exp_q = {}; rx_q = {}; doe_drop = 0;
    randomize_inputs();
    randomize_reads();
    add_exp(seg, led, brightness);
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    randomize_inputs();
    wait_done();
    d = stream_diff();
    checks++;
    if (!w_seen || d != 0) begin
      errors++;
      $display("FAIL random_stream seen=%0d diff=%0d got %0d bytes required %0d", w_seen, d, rx_q.size(), exp_q.size());
    end
    checks++;
    if (w_keys !== model_keys() || w_kv !== exp_kv()) begin
      errors++;
      $display("FAIL random_keys keys=%h kv=%b required keys=%h kv=%b", w_keys, w_kv, model_keys(), exp_kv());
    end
`ifndef TM1638_KEY_SCAN_EN
    checks++;
    if (doe_drop != 0) begin
      errors++;
      $display("FAIL random_doe_hold doe low for %0d busy cycles required 0", doe_drop);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_pending();
    int busy_low, dones, extra, d;
    exp_q = {}; rx_q = {};
    randomize_inputs();
    randomize_reads();
    rd_bytes[0][0] = 1'b1;  // keys nonzero afterwards, used by the reset test
    add_exp(seg, led, brightness);
    add_exp(seg, led, brightness);
    busy_low = 0; dones = 0; extra = 0;
    frame_req = 1'b1;
    for (int i = 0; i < 20000 && dones < 2; i++) begin
      @(negedge clk);
      frame_req = (i == 1000 || i == 3000 || i == 5000);
      if (!busy) busy_low++;
      if (frame_done) dones++;
    end
    frame_req = 1'b0;
    checks++;
    if (dones != 2 || busy_low != 0) begin
      errors++;
      $display("FAIL pending_merge frames=%0d busy_low=%0d required 2 0", dones, busy_low);
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (frame_done) extra++;
    end
    checks++;
    if (extra != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pending_no_extra extra=%0d busy=%b required 0 0", extra, busy);
    end
    d = stream_diff();
    checks++;
    if (d != 0) begin
      errors++;
      $display("FAIL pending_stream diff=%0d got %0d bytes required %0d", d, rx_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid_and_done_req();
    int d;
    bit hit;
    logic [7:0] prev_keys;
    prev_keys = model_keys();
    checks++;
    if (keys !== prev_keys) begin
      errors++;
      $display("FAIL keys_before_reset keys=%h required %h", keys, prev_keys);
    end
    rx_q = {};
    randomize_inputs();
    randomize_reads();
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    hit = 0;
    for (int i = 0; i < 12000 && !hit; i++) begin
      @(negedge clk);
`ifdef TM1638_KEY_SCAN_EN
      if (rb >= 17) hit = 1;
`else
      if (rx_q.size() >= 6) hit = 1;
`endif
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid_reach target phase never reached");
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({sio_stb, sio_clk, sio_dout, sio_doe, busy, frame_done, key_valid} !== 7'b1110000 || keys !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_values stb/clk/dout/doe/busy/done/kv=%b keys=%h required 1110000 keys=00",
               {sio_stb, sio_clk, sio_dout, sio_doe, busy, frame_done, key_valid}, keys);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || keys !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_idle busy=%b keys=%h required 0 00", busy, keys);
    end
    // Recovery frame, then a request landing exactly in its frame_done cycle.
    exp_q = {}; rx_q = {};
    randomize_inputs();
    randomize_reads();
    add_exp(seg, led, brightness);
    add_exp(seg, led, brightness);
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    wait_done();
    checks++;
    if (!w_seen || w_keys !== model_keys() || w_kv !== exp_kv()) begin
      errors++;
      $display("FAIL recovery_frame seen=%0d keys=%h kv=%b required 1 keys=%h kv=%b",
               w_seen, w_keys, w_kv, model_keys(), exp_kv());
    end
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL done_req_restart busy=%b required 1", busy);
    end
    wait_done();
    w_cyc++;
    checks++;
    if (!w_seen || w_cyc != frame_cycles()) begin
      errors++;
      $display("FAIL done_req_frame seen=%0d cycles=%0d required 1 %0d", w_seen, w_cyc, frame_cycles());
    end
    repeat (60) @(negedge clk);
    d = stream_diff();
    checks++;
    if (d != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_req_stream diff=%0d busy=%b got %0d bytes required %0d", d, busy, rx_q.size(), exp_q.size());
    end
  endtask

  initial begin
    for (int b = 0; b < 4; b++) rd_bytes[b] = 8'h00;
    test_reset();
    test_basic_frame();
    test_random_frame();
    test_pending();
    test_reset_mid_and_done_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
